// File: rtl/alu_muldiv_seq.sv
// Handshaked execute unit: single-cycle ALU ops plus iterative unsigned
// multiply and restoring divide, one bit per cycle, with synchronous flush.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic [TAG_W-1:0]   out_tag,
  output logic               div_by_zero,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ANDN = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_SEQ  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLE  = 4'd10;
  localparam logic [3:0] OP_SCO  = 4'd11;
  localparam logic [3:0] OP_BTR  = 4'd12;
  localparam logic [3:0] OP_MULU = 4'd13;
  localparam logic [3:0] OP_DIVU = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                 state_q, state_d, start_state_c;
  logic [CNT_W-1:0]       cnt_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]       opnd_q;
  logic [TAG_W-1:0]       tag_q;

  logic                   accept_c, is_mul_c, is_div_c, div_zero_c, is_iter_c;
  logic [SHAMT_W-1:0]     sh_c;
  logic [WIDTH:0]         sum_c;
  logic [2*WIDTH-1:0]     dbl_c, rol_c, ror_c;
  logic [WIDTH-1:0]       btr_c, alu_c;
  logic [WIDTH:0]         mul_sum_c, div_sh_c, div_diff_c;
  logic                   div_ge_c;
  logic [2*WIDTH-1:0]     mul_step_c, div_step_c, step_c;

  // Handshake and op classification
  assign in_ready   = rst & ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept_c   = in_valid & in_ready;
  assign is_mul_c   = (op == OP_MULU);
  assign is_div_c   = (op == OP_DIVU);
  assign div_zero_c = is_div_c & (b == '0);
  assign is_iter_c  = is_mul_c | (is_div_c & ~div_zero_c);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);

  // Shared shift/rotate and adder terms; rotates come from a doubled operand
  assign sh_c  = b[SHAMT_W-1:0];
  assign sum_c = {1'b0, a} + {1'b0, b};
  assign dbl_c = {a, a};
  assign rol_c = dbl_c << sh_c;
  assign ror_c = dbl_c >> sh_c;

  // Single-cycle result mux; a zero-divisor DIVU resolves here as all ones
  always_comb begin
    alu_c = '0;
    btr_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) btr_c[i] = a[WIDTH-1-i];
    case (op)
      OP_ADD:  alu_c = sum_c[WIDTH-1:0];
      OP_SUB:  alu_c = a - b;
      OP_XOR:  alu_c = a ^ b;
      OP_ANDN: alu_c = a & ~b;
      OP_SLL:  alu_c = a << sh_c;
      OP_SRL:  alu_c = a >> sh_c;
      OP_ROL:  alu_c = rol_c[2*WIDTH-1:WIDTH];
      OP_ROR:  alu_c = ror_c[WIDTH-1:0];
      OP_SEQ:  alu_c = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SLT:  alu_c = {{(WIDTH-1){1'b0}}, ($signed(a) <  $signed(b))};
      OP_SLE:  alu_c = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
      OP_SCO:  alu_c = {{(WIDTH-1){1'b0}}, sum_c[WIDTH]};
      OP_BTR:  alu_c = btr_c;
      OP_DIVU: alu_c = '1;
      default: alu_c = '0;
    endcase
  end

  // Multiply step: multiplier sits in acc low half and shifts out LSB first
  assign mul_sum_c  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step_c = {mul_sum_c, acc_q[WIDTH-1:1]};

  // Restoring divide step: remainder in high half, quotient bits enter at LSB
  assign div_sh_c   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge_c   = (div_sh_c >= {1'b0, opnd_q});
  assign div_diff_c = div_sh_c - {1'b0, opnd_q};
  assign div_step_c = {(div_ge_c ? div_diff_c[WIDTH-1:0] : div_sh_c[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge_c};
  assign step_c     = (state_q == S_MUL) ? mul_step_c : div_step_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d       = state_q;
    start_state_c = S_DONE;
    if (is_iter_c) start_state_c = is_mul_c ? S_MUL : S_DIV;
    case (state_q)
      S_IDLE: if (accept_c) state_d = start_state_c;
      S_MUL,
      S_DIV:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE: begin
        if (accept_c)       state_d = start_state_c;
        else if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Operand latch, iteration datapath and registered result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      tag_q       <= '0;
      result      <= '0;
      result_hi   <= '0;
      out_tag     <= '0;
      div_by_zero <= 1'b0;
    end else if (accept_c) begin
      cnt_q  <= CNT_W'(WIDTH);
      tag_q  <= in_tag;
      opnd_q <= is_mul_c ? a : b;
      acc_q  <= is_mul_c ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      if (!is_iter_c) begin
        result      <= alu_c;
        result_hi   <= div_zero_c ? a : '0;
        div_by_zero <= div_zero_c;
        out_tag     <= in_tag;
      end
    end else if (!flush && ((state_q == S_MUL) || (state_q == S_DIV))) begin
      acc_q <= step_c;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        result      <= step_c[WIDTH-1:0];
        result_hi   <= step_c[2*WIDTH-1:WIDTH];
        out_tag     <= tag_q;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq at WIDTH=16 and WIDTH=32 with a result scoreboard.
module tb_alu_muldiv_seq;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ANDN = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_SEQ  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLE  = 4'd10;
  localparam logic [3:0] OP_SCO  = 4'd11;
  localparam logic [3:0] OP_BTR  = 4'd12;
  localparam logic [3:0] OP_MULU = 4'd13;
  localparam logic [3:0] OP_DIVU = 4'd14;
  localparam logic [3:0] OP_RSV  = 4'd15;

  typedef struct packed {
    logic [2:0]  tag;
    logic [31:0] res;
    logic [31:0] hi;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, drv_valid, out_ready, sel;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [2:0]  in_tag;

  logic        in_ready16, out_valid16, dbz16, busy16;
  logic [15:0] result16, result_hi16;
  logic [2:0]  out_tag16;
  logic        in_ready32, out_valid32, dbz32, busy32;
  logic [31:0] result32, result_hi32;
  logic [2:0]  out_tag32;

  logic        o_valid, o_in_ready, o_dbz, o_busy;
  logic [31:0] o_result, o_hi;
  logic [2:0]  o_tag;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(16), .TAG_W(3)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(drv_valid & ~sel), .in_ready(in_ready16),
    .op(op), .a(a[15:0]), .b(b[15:0]), .in_tag(in_tag), .out_valid(out_valid16),
    .out_ready(out_ready), .result(result16), .result_hi(result_hi16), .out_tag(out_tag16),
    .div_by_zero(dbz16), .busy(busy16)
  );

  alu_muldiv_seq #(.WIDTH(32), .TAG_W(3)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(drv_valid & sel), .in_ready(in_ready32),
    .op(op), .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .result(result32), .result_hi(result_hi32), .out_tag(out_tag32),
    .div_by_zero(dbz32), .busy(busy32)
  );

  assign o_valid    = sel ? out_valid32 : out_valid16;
  assign o_in_ready = sel ? in_ready32  : in_ready16;
  assign o_dbz      = sel ? dbz32       : dbz16;
  assign o_busy     = sel ? busy32      : busy16;
  assign o_result   = sel ? result32    : {16'h0, result16};
  assign o_hi       = sel ? result_hi32 : {16'h0, result_hi16};
  assign o_tag      = sel ? out_tag32   : out_tag16;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  // Present one op at a negedge, expect it accepted at the next posedge.
  task automatic send(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [2:0] t, input logic [31:0] er, input logic [31:0] eh,
                      input logic ed);
    op = o; a = aa; b = bb; in_tag = t; drv_valid = 1'b1;
    #1;
    check("in_ready_at_issue", 64'(o_in_ready), 64'd1);
    sb_q.push_back('{tag: t, res: er, hi: eh, dbz: ed});
    @(negedge clk);
    drv_valid = 1'b0;
  endtask

  task automatic check_out(input string name);
    exp_t e;
    check({name, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({name, "_valid"},  64'(o_valid),  64'd1);
      check({name, "_result"}, 64'(o_result), 64'(e.res));
      check({name, "_hi"},     64'(o_hi),     64'(e.hi));
      check({name, "_tag"},    64'(o_tag),    64'(e.tag));
      check({name, "_dbz"},    64'(o_dbz),    64'(e.dbz));
    end
  endtask

  // Called at the first negedge after accept; counts cycles to out_valid.
  task automatic wait_out(input string name, input int exp_lat);
    int lat = 1;
    int ir_bad = 0;
    while (!o_valid && lat < 100) begin
      if (o_in_ready !== 1'b0) ir_bad++;
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_in_ready_low"}, 64'(ir_bad), 64'd0);
    check_out(name);
    @(negedge clk);
  endtask

  logic [3:0]  t_op  [13] = '{OP_ROR, OP_SLT, OP_SLT, OP_SLE, OP_SEQ, OP_SLL, OP_SRL,
                              OP_ROL, OP_ANDN, OP_BTR, OP_BTR, OP_SUB, OP_RSV};
  logic [31:0] t_a   [13] = '{32'h0001, 32'h8000, 32'h0001, 32'h0005, 32'h0007, 32'h1234, 32'h8000,
                              32'h8001, 32'hFFFF, 32'h0001, 32'h1234, 32'h0000, 32'hFFFF};
  logic [31:0] t_b   [13] = '{32'h0011, 32'h0001, 32'h8000, 32'h0005, 32'h0008, 32'h0010, 32'h000F,
                              32'h0001, 32'h00F0, 32'h0000, 32'h0000, 32'h0001, 32'hFFFF};
  logic [31:0] t_exp [13] = '{32'h8000, 32'h0001, 32'h0000, 32'h0001, 32'h0000, 32'h1234, 32'h0001,
                              32'h0003, 32'hFF0F, 32'h8000, 32'h2C48, 32'hFFFF, 32'h0000};

  initial begin
    int seen;
    rst = 1'b0; flush = 1'b0; drv_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
    op = '0; a = '0; b = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(o_valid),    64'd0);
    check("rst_in_ready",  64'(o_in_ready), 64'd0);
    check("rst_busy",      64'(o_busy),     64'd0);
    check("rst_result",    64'(o_result),   64'd0);
    rst = 1'b1;
    #1 check("in_ready_after_rst", 64'(o_in_ready), 64'd1);
    @(negedge clk);

    send(OP_ADD, 32'hFFFF, 32'h0001, 3'd1, 32'h0000, 32'h0, 1'b0);  wait_out("add_wrap", 1);
    send(OP_SCO, 32'hFFFF, 32'h0001, 3'd2, 32'h0001, 32'h0, 1'b0);  wait_out("sco", 1);
    send(OP_SCO, 32'h8000, 32'h7FFF, 3'd3, 32'h0000, 32'h0, 1'b0);  wait_out("sco_nocarry", 1);
    send(OP_MULU, 32'h1234, 32'h0100, 3'd3, 32'h3400, 32'h0012, 1'b0); wait_out("mulu16", 17);
    send(OP_MULU, 32'hFFFF, 32'hFFFF, 3'd4, 32'h0001, 32'hFFFE, 1'b0); wait_out("mulu16_max", 17);
    send(OP_DIVU, 32'd100, 32'd7, 3'd5, 32'd14, 32'd2, 1'b0);         wait_out("divu16", 17);
    send(OP_DIVU, 32'hFFFF, 32'd1, 3'd6, 32'hFFFF, 32'd0, 1'b0);      wait_out("divu16_by1", 17);
    send(OP_DIVU, 32'd100, 32'd0, 3'd7, 32'hFFFF, 32'd100, 1'b1);     wait_out("divz16", 1);

    // Backpressure in DONE, then a back-to-back accept on release
    out_ready = 1'b0;
    send(OP_SUB, 32'h0005, 32'h0007, 3'd3, 32'hFFFE, 32'h0, 1'b0);
    check("bp_valid", 64'(o_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid",    64'(o_valid),    64'd1);
      check("bp_hold_result",   64'(o_result),   64'hFFFE);
      check("bp_hold_tag",      64'(o_tag),      64'd3);
      check("bp_hold_in_ready", 64'(o_in_ready), 64'd0);
    end
    out_ready = 1'b1;
    op = OP_XOR; a = 32'h00FF; b = 32'h0F0F; in_tag = 3'd4; drv_valid = 1'b1;
    #1 check("b2b_in_ready", 64'(o_in_ready), 64'd1);
    check_out("bp_sub");
    sb_q.push_back('{tag: 3'd4, res: 32'h0FF0, hi: 32'h0, dbz: 1'b0});
    @(negedge clk);
    drv_valid = 1'b0;
    wait_out("b2b_xor", 1);

    // Flush on the 8th cycle of a multiply
    send(OP_MULU, 32'h1234, 32'h0100, 3'd5, 32'h3400, 32'h0012, 1'b0);
    void'(sb_q.pop_back());
    repeat (7) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_in_ready", 64'(o_in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_out_valid", 64'(o_valid), 64'd0);
    check("flush_busy",      64'(o_busy),  64'd0);
    #1 check("flush_in_ready_after", 64'(o_in_ready), 64'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    check("flush_no_out", 64'(seen), 64'd0);

    // Asynchronous reset during a divide
    send(OP_DIVU, 32'd1000, 32'd3, 3'd6, 32'd333, 32'd1, 1'b0);
    void'(sb_q.pop_back());
    repeat (4) @(negedge clk);
    check("div_busy_pre_rst", 64'(o_busy), 64'd1);
    rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(o_valid),    64'd0);
    check("arst_result",    64'(o_result),   64'd0);
    check("arst_hi",        64'(o_hi),       64'd0);
    check("arst_tag",       64'(o_tag),      64'd0);
    check("arst_dbz",       64'(o_dbz),      64'd0);
    check("arst_busy",      64'(o_busy),     64'd0);
    check("arst_in_ready",  64'(o_in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("arst_in_ready_release", 64'(o_in_ready), 64'd1);
    @(negedge clk);

    // Single-cycle op table (shifts, rotates, compares, bit-reverse, reserved)
    for (int i = 0; i < 13; i++) begin
      send(t_op[i], t_a[i], t_b[i], 3'(i), t_exp[i], 32'h0, 1'b0);
      wait_out($sformatf("alu_%0d", i), 1);
    end

    // WIDTH=32 instance
    sel = 1'b1;
    @(negedge clk);
    send(OP_ADD, 32'hFFFFFFFF, 32'h1, 3'd1, 32'h0, 32'h0, 1'b0);             wait_out("add32", 1);
    send(OP_MULU, 32'h1234, 32'h0100, 3'd2, 32'h00123400, 32'h0, 1'b0);      wait_out("mulu32", 33);
    send(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 32'h1, 32'hFFFFFFFE, 1'b0); wait_out("mulu32_max", 33);
    send(OP_DIVU, 32'd100, 32'd7, 3'd4, 32'd14, 32'd2, 1'b0);                wait_out("divu32", 33);
    send(OP_DIVU, 32'd100, 32'd0, 3'd5, 32'hFFFFFFFF, 32'd100, 1'b1);        wait_out("divz32", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
